// File: rtl/knn_vote.sv
// knn_vote: majority vote over a K-entry nearest-neighbour list.
// A start request latches the list, TALLY counts one entry per cycle into
// N per-label counters, SCAN walks the counters to find the winner (lowest
// label wins ties), and DONE presents the result until it is accepted.
//
// Result handshake: the result transfers on the rising edge where
// out_valid=1 and out_ready=1 are both sampled; out_valid never depends
// combinationally on out_ready, and class_out/votes/err stay stable while
// out_valid is high and the transfer has not happened yet.
module knn_vote #(
  parameter int K         = 4,
  parameter int N         = 10,
  parameter int DATA_INFO = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K*DATA_INFO-1:0] nb_list,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             class_out,
  output logic [7:0]             votes,
  output logic                   err,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TALLY = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [8:0] K_LAST = 9'(K - 1);
  localparam logic [8:0] N_LAST = 9'(N - 1);
  localparam logic [8:0] N_W    = 9'(N);

  state_t                 state;
  logic [K*DATA_INFO-1:0] nb_reg;
  logic [7:0]             cnt [N];
  logic [8:0]             step;
  logic [7:0]             best_label;
  logic [7:0]             best_cnt;

  logic [7:0]             cur_label;
  logic                   label_ok;
  logic [7:0]             scan_cnt;

  assign state_dbg = state;

  // Select the label of the entry being tallied this cycle.
  always_comb begin
    cur_label = '0;
    for (int i = 0; i < K; i++) begin
      if (step == 9'(i)) cur_label = nb_reg[i*DATA_INFO +: 8];
    end
    label_ok = ({1'b0, cur_label} < N_W);
  end

  // Select the counter being inspected this SCAN cycle.
  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (step == 9'(i)) scan_cnt = cnt[i];
    end
  end

  // Control FSM with registered outputs, counters and running best.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      nb_reg     <= '0;
      step       <= '0;
      best_label <= '0;
      best_cnt   <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      class_out  <= '0;
      votes      <= '0;
      err        <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nb_reg     <= nb_list;
            step       <= '0;
            best_label <= 8'hFF;
            best_cnt   <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
            state      <= TALLY;
          end
        end
        TALLY: begin
          if (label_ok) begin
            for (int i = 0; i < N; i++) begin
              if (cur_label == 8'(i)) cnt[i] <= cnt[i] + 8'd1;
            end
          end else begin
            err <= 1'b1;
          end
          if (step == K_LAST) begin
            step  <= '0;
            state <= SCAN;
          end else begin
            step <= step + 9'd1;
          end
        end
        SCAN: begin
          // Strictly-greater replacement keeps the lowest label on ties.
          if (scan_cnt > best_cnt) begin
            best_cnt   <= scan_cnt;
            best_label <= step[7:0];
          end
          if (step == N_LAST) begin
            step  <= '0;
            state <= DONE;
          end else begin
            step <= step + 9'd1;
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; afterwards wait for accept.
          if (!out_valid) begin
            class_out <= best_label;
            votes     <= best_cnt;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Directed testbench for knn_vote (K=4, N=10, DATA_INFO=40).
module tb_knn_vote;

  localparam int K  = 4;
  localparam int N  = 10;
  localparam int DI = 40;
  localparam int LATENCY = K + N + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [K*DI-1:0]   nb_list;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        class_out;
  logic [7:0]        votes;
  logic              err;
  logic [1:0]        state_dbg;

  int checks;
  int failures;
  int lat;
  int bcnt;
  logic stable_ok;

  knn_vote #(.K(K), .N(N), .DATA_INFO(DI)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nb_list   (nb_list),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_out (class_out),
    .votes     (votes),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build a neighbour list; distances are arbitrary and ignored by the vote.
  function automatic logic [K*DI-1:0] mk_list(input logic [7:0] l0, input logic [7:0] l1,
                                               input logic [7:0] l2, input logic [7:0] l3);
    logic [K*DI-1:0] v;
    logic [7:0]      labs [K];
    labs[0] = l0; labs[1] = l1; labs[2] = l2; labs[3] = l3;
    v = '0;
    for (int i = 0; i < K; i++) begin
      v[i*DI +: DI] = {32'(32'h100 + i * 7), labs[i]};
    end
    return v;
  endfunction

  function automatic logic [K*DI-1:0] rand_list();
    logic [K*DI-1:0] v;
    for (int i = 0; i < K*DI; i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  // Driver: pulse start for one edge; returns just after the start edge.
  task automatic issue_start(input logic [K*DI-1:0] lst);
    start   = 1'b1;
    nb_list = lst;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for out_valid (bounded), measuring latency from the start edge and
  // busy-high cycles; optionally scramble nb_list during the first cycles.
  task automatic wait_valid(input int scramble, output int l, output int b);
    l = 0;
    b = busy ? 1 : 0;
    while (!out_valid && l < 40) begin
      if (l < scramble) nb_list = rand_list();
      @(posedge clk); #1;
      l++;
      if (busy) b++;
    end
  endtask

  // Complete the handshake and confirm out_valid drops with results held.
  task automatic accept(input string tag, input logic [7:0] exp_cls, input logic [7:0] exp_votes);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_cls_hold"}, class_out, exp_cls);
    check({tag, "_votes_hold"}, votes, exp_votes);
  endtask

  task automatic run_case(input string tag, input logic [K*DI-1:0] lst,
                          input logic [7:0] exp_cls, input logic [7:0] exp_votes, input logic exp_err);
    int l, b;
    out_ready = 1'b1;
    issue_start(lst);
    wait_valid(0, l, b);
    check({tag, "_latency"}, l, LATENCY);
    check({tag, "_class"}, class_out, exp_cls);
    check({tag, "_votes"}, votes, exp_votes);
    check({tag, "_err"}, err, exp_err);
    accept(tag, exp_cls, exp_votes);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    nb_list   = '0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_class", class_out, 0);
    check("rst_votes", votes, 0);
    check("rst_err", err, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic majority with busy window measurement
    out_ready = 1'b1;
    issue_start(mk_list(8'd3, 8'd3, 8'd7, 8'd1));
    check("basic_busy_at_start", busy, 1);
    wait_valid(0, lat, bcnt);
    check("basic_latency", lat, LATENCY);
    check("basic_busy_cycles", bcnt, LATENCY);
    check("basic_busy_low", busy, 0);
    check("basic_class", class_out, 3);
    check("basic_votes", votes, 2);
    check("basic_err", err, 0);
    accept("basic", 8'd3, 8'd2);

    // Tie resolves to the lowest label
    run_case("tie", mk_list(8'd7, 8'd2, 8'd7, 8'd2), 8'd2, 8'd2, 1'b0);
    // Invalid labels are skipped and flagged
    run_case("inv", mk_list(8'd12, 8'd5, 8'd255, 8'd5), 8'd5, 8'd2, 1'b1);
    // All invalid: no winner
    run_case("none", mk_list(8'd10, 8'd11, 8'd12, 8'd13), 8'hFF, 8'd0, 1'b1);
    // Boundary labels 9 (valid) and 0
    run_case("edge", mk_list(8'd9, 8'd0, 8'd9, 8'd0), 8'd0, 8'd2, 1'b0);

    // Backpressure: hold result, ignore a start pulse
    out_ready = 1'b0;
    issue_start(mk_list(8'd1, 8'd1, 8'd1, 8'd0));
    wait_valid(0, lat, bcnt);
    check("bp_latency", lat, LATENCY);
    check("bp_class", class_out, 1);
    check("bp_votes", votes, 3);
    stable_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      start   = (c == 10);
      nb_list = mk_list(8'd8, 8'd8, 8'd8, 8'd8);
      @(posedge clk); #1;
      if (!(out_valid === 1'b1 && class_out === 8'd1 && votes === 8'd3 &&
            err === 1'b0 && busy === 1'b0)) stable_ok = 1'b0;
    end
    start = 1'b0;
    check("bp_stable", stable_ok, 1);
    // Handshake edge with start high: start must be ignored
    out_ready = 1'b1;
    start     = 1'b1;
    nb_list   = mk_list(8'd4, 8'd4, 8'd4, 8'd4);
    @(posedge clk); #1;
    check("bp_hs_valid", out_valid, 0);
    check("bp_hs_busy", busy, 0);
    check("bp_hs_state", state_dbg, 0);
    // Next edge: start accepted
    @(posedge clk); #1;
    start = 1'b0;
    check("bp_restart_busy", busy, 1);
    wait_valid(0, lat, bcnt);
    check("bp_restart_latency", lat, LATENCY);
    check("bp_restart_class", class_out, 4);
    check("bp_restart_votes", votes, 4);
    accept("bp_restart", 8'd4, 8'd4);

    // nb_list changes during TALLY must not matter
    issue_start(mk_list(8'd6, 8'd6, 8'd0, 8'd9));
    wait_valid(6, lat, bcnt);
    check("latch_latency", lat, LATENCY);
    check("latch_class", class_out, 6);
    check("latch_votes", votes, 2);
    check("latch_err", err, 0);
    accept("latch", 8'd6, 8'd2);

    // Reset in the middle of SCAN (edge 8 after start)
    issue_start(mk_list(8'd2, 8'd2, 8'd2, 8'd9));
    repeat (7) @(posedge clk);
    #1;
    check("mid_state_scan", state_dbg, 2);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_class", class_out, 0);
    check("mid_rst_votes", votes, 0);
    check("mid_rst_state", state_dbg, 0);
    // Start driven together with reset release is taken on the first edge
    rst     = 1'b1;
    start   = 1'b1;
    nb_list = mk_list(8'd2, 8'd2, 8'd2, 8'd9);
    @(posedge clk); #1;
    start = 1'b0;
    check("post_rst_busy", busy, 1);
    wait_valid(0, lat, bcnt);
    check("post_rst_latency", lat, LATENCY);
    check("post_rst_class", class_out, 2);
    check("post_rst_votes", votes, 3);
    check("post_rst_err", err, 0);
    accept("post_rst", 8'd2, 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
